// File: rtl/data_mem_if.sv
// Request/response channel between the MEM stage and the data-memory controller.
// The master issues requests and consumes responses; the slave is the controller.
interface data_mem_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_addr;
    logic            req_we;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-lane synchronous data RAM behind a valid/ready request channel with a
// registered response, alignment/range/size checking and error reporting.
//
// state | meaning
// IDLE  | ready for a new request
// RD    | RAM word captured, extract and extend the addressed bytes
// RESP  | response presented, held until resp_ready
module data_mem_ctrl #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic     clk_i,
    input  logic     resetn_i,
    data_mem_if.slave bus
);
    localparam int          NB   = XLEN / 8;
    localparam int          OFFW = $clog2(NB);
    localparam logic [32:0] CAP  = 33'(NB) << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t                state_q, state_d;
    logic [XLEN-1:0]       mem [2**DEPTH_LOG2];
    logic [XLEN-1:0]       ram_q;
    logic [OFFW-1:0]       off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic [1:0]            err_q, err_d;

    logic                  accept;
    logic [1:0]            req_err;
    logic                  misaligned;
    logic [OFFW-1:0]       req_off;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [7:0]            lanes;
    logic [NB-1:0]         be;
    logic [XLEN-1:0]       wdata_sh;
    logic [XLEN-1:0]       shifted;
    logic [XLEN-1:0]       ext;

    assign accept   = bus.req_valid && (state_q == IDLE);
    assign req_off  = bus.req_addr[OFFW-1:0];
    assign req_idx  = bus.req_addr[OFFW +: DEPTH_LOG2];
    assign be       = NB'(lanes << req_off);
    assign wdata_sh = bus.req_wdata << {req_off, 3'b000};
    assign shifted  = ram_q >> {off_q, 3'b000};

    always_comb begin
        lanes      = 8'hFF;
        misaligned = |bus.req_addr[2:0];
        case (bus.req_size)
            2'd0: begin lanes = 8'h01; misaligned = 1'b0;              end
            2'd1: begin lanes = 8'h03; misaligned = bus.req_addr[0];    end
            2'd2: begin lanes = 8'h0F; misaligned = |bus.req_addr[1:0]; end
            default: ;
        endcase
    end

    // Priority: illegal size, then misalignment, then range.
    always_comb begin
        req_err = 2'd0;
        if (bus.req_size == 2'd3 && XLEN == 32)
            req_err = 2'd3;
        else if (misaligned)
            req_err = 2'd1;
        else if ({1'b0, bus.req_addr} >= CAP)
            req_err = 2'd2;
    end

    always_comb begin
        ext = shifted;
        case (size_q)
            2'd0: ext = uns_q ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            2'd1: ext = uns_q ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            2'd2: ext = uns_q ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: ;
        endcase
    end

    // Storage is not reset; a store commits on its accept edge so a later load never needs forwarding.
    always_ff @(posedge clk_i) begin
        if (resetn_i && accept && req_err == 2'd0) begin
            if (bus.req_we) begin
                for (int b = 0; b < NB; b++)
                    if (be[b]) mem[req_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end else begin
                ram_q <= mem[req_idx];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    off_d   = req_off;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    rdata_d = '0;
                    err_d   = req_err;
                    state_d = (req_err != 2'd0 || bus.req_we) ? RESP : RD;
                end
            end
            RD: begin
                rdata_d = ext;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
